fsm_add_decoder: RTL and testbench

- Inverse of the team's sequential subtractor (delta encoder) block.
- Receives framed 8-bit delta streams and reconstructs the original unsigned samples by running accumulation.
- Sits at the receive end of the delta link. Upstream and downstream are valid/ready streams with a single registered output stage.
- A frame is one absolute seed sample followed by sin deltas, so frame length is sin+1.

---
 rtl/fsm_add_decoder.sv | 116 +++++++++++
 tb/tb_fsm_add_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_add_decoder.sv
// Delta decoder: rebuilds unsigned samples from framed seed+delta streams by running accumulation.
// Build option FSM_ADD_SAT_EN clamps out-of-range reconstructions instead of wrapping them.
module fsm_add_decoder #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] sin,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          ovf
);

    typedef enum logic {SEED = 1'b0, RUN = 1'b1} state_t;

    state_t              state_p1, state_nxt;
    logic [W-1:0]        acc_p1, acc_nxt;
    logic [CW-1:0]       cnt_p1, cnt_nxt;
    logic [CW-1:0]       len_p1, len_nxt;
    logic [CW-1:0]       cnt_inc_p0;
    logic                accept_p0;
    logic signed [W+1:0] sum_p0;
    logic [W-1:0]        out_data_nxt;
    logic                out_valid_nxt, out_last_nxt, ovf_nxt;

    function automatic logic out_of_range(input logic signed [W+1:0] s);
        return (s < 0) || (s > $signed({2'b00, {W{1'b1}}}));
    endfunction

    function automatic logic [W-1:0] fit(input logic signed [W+1:0] s);
`ifdef FSM_ADD_SAT_EN
        if (s < 0)
            return '0;
        if (out_of_range(s))
            return '1;
`endif
        return s[W-1:0];
    endfunction

    assign in_ready   = !out_valid || out_ready;
    assign accept_p0  = in_valid && in_ready;
    assign cnt_inc_p0 = cnt_p1 + CW'(1);
    // Two guard bits hold both the carry above 2^W-1 and the sign below 0.
    assign sum_p0     = $signed({2'b00, acc_p1}) + $signed({{2{in_data[W-1]}}, in_data});

    always_ff @(posedge clock) begin
        if (reset)
            state_p1 <= SEED;
        else
            state_p1 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p1;
        if (accept_p0) begin
            if (state_p1 == SEED)
                state_nxt = (sin == '0) ? SEED : RUN;
            else if (cnt_inc_p0 == len_p1)
                state_nxt = SEED;
        end
    end

    always_comb begin
        acc_nxt       = acc_p1;
        cnt_nxt       = cnt_p1;
        len_nxt       = len_p1;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid && !out_ready;
        if (accept_p0) begin
            out_valid_nxt = 1'b1;
            if (state_p1 == SEED) begin
                acc_nxt      = in_data;
                out_data_nxt = in_data;
                len_nxt      = sin;
                cnt_nxt      = '0;
                out_last_nxt = (sin == '0);
            end else begin
                acc_nxt      = fit(sum_p0);
                out_data_nxt = fit(sum_p0);
                cnt_nxt      = cnt_inc_p0;
                out_last_nxt = (cnt_inc_p0 == len_p1);
                ovf_nxt      = ovf || out_of_range(sum_p0);
            end
        end
    end

    // Output stage: one registered sample, held while downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p1    <= '0;
            cnt_p1    <= '0;
            len_p1    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            acc_p1    <= acc_nxt;
            cnt_p1    <= cnt_nxt;
            len_p1    <= len_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
            out_valid <= out_valid_nxt;
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fsm_add_decoder.sv
// Bench for fsm_add_decoder: directed scenarios plus random framed streams against a frame-level model.
module tb_fsm_add_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sin = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    int bq[$];
    int sq[$];
    int eq[$];
    int lq[$];
    int fd[0:7];
    int dsin = -1;
    bit exp_ovf = 1'b0;

    fsm_add_decoder #(.W(8), .CW(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .sin       (sin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Frame model: running sum in plain integers, then wrap or clamp into 0..255.
    task automatic push_frame(input int n);
        int a;
        int s;
        a = fd[0];
        bq.push_back(fd[0]);
        sq.push_back(n);
        eq.push_back(a);
        lq.push_back((n == 0) ? 1 : 0);
        for (int i = 1; i <= n; i++) begin
            s = a + ((fd[i] >= 128) ? fd[i] - 256 : fd[i]);
            if (s < 0 || s > 255)
                exp_ovf = 1'b1;
`ifdef FSM_ADD_SAT_EN
            s = (s < 0) ? 0 : ((s > 255) ? 255 : s);
`else
            s = s & 255;
`endif
            a = s;
            bq.push_back(fd[i]);
            sq.push_back((dsin >= 0) ? dsin : int'($urandom_range(0, 7)));
            eq.push_back(a);
            lq.push_back((i == n) ? 1 : 0);
        end
    endtask

    // rmode/vmode 0 = always ready/valid, 1 = random stalls.
    task automatic run(input int rmode, input int vmode, input int budget);
        int   cyc;
        bit   prev_acc;
        bit   prev_hold;
        logic [7:0] held_data;
        logic held_last;
        cyc = 0;
        prev_acc = 1'b0;
        prev_hold = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        while ((bq.size() > 0 || eq.size() > 0) && cyc < budget) begin
            @(negedge clock);
            in_valid  = (bq.size() > 0) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_data   = (bq.size() > 0) ? 8'(bq[0]) : 8'($urandom);
            sin       = (bq.size() > 0) ? 3'(sq[0]) : 3'($urandom);
            out_ready = (rmode == 0) || ($urandom_range(0, 2) != 0);
            #1;
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (rmode == 0)
                chk("latency_valid", out_valid, prev_acc);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_data);
                chk("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk("extra_output", eq.size(), 1);
                end else begin
                    chk("out_data", out_data, eq[0]);
                    chk("out_last", out_last, lq[0]);
                    void'(eq.pop_front());
                    void'(lq.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            prev_acc  = in_valid && in_ready;
            if (in_valid && in_ready) begin
                void'(bq.pop_front());
                void'(sq.pop_front());
            end
            cyc++;
        end
        chk("timeout", (cyc < budget) ? 1 : 0, 1);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("drained_valid", out_valid, 0);
        chk("ovf_flag", ovf, exp_ovf);
        bq.delete();
        sq.delete();
        eq.delete();
        lq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic frame
        fd[0] = 8; fd[1] = 15; fd[2] = 16;
        push_frame(2);
        run(0, 0, 50);

        // Negative deltas
        fd[0] = 110; fd[1] = 'hDC; fd[2] = 'hF7; fd[3] = 'hD2;
        push_frame(3);
        run(0, 0, 50);

        // Backpressure
        @(negedge clock);
        in_valid = 1'b1; in_data = 8; sin = 3'd2; out_ready = 1'b0;
        #1 chk("bp_ready_idle", in_ready, 1);
        @(negedge clock);
        in_data = 15;
        #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_data0", out_data, 8);
        chk("bp_ready_stall", in_ready, 0);
        repeat (3) begin
            @(negedge clock);
            #1;
            chk("bp_hold_data", out_data, 8);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1 chk("bp_ready_release", in_ready, 1);
        @(negedge clock);
        in_data = 16;
        #1;
        chk("bp_data1", out_data, 23);
        chk("bp_last1", out_last, 0);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("bp_data2", out_data, 39);
        chk("bp_last2", out_last, 1);
        @(negedge clock);
        #1;
        chk("bp_end_valid", out_valid, 0);
        chk("bp_ovf", ovf, 0);

        // Overflow above and below range, sticky flag
        fd[0] = 200; fd[1] = 100;
        push_frame(1);
        run(0, 0, 50);
        fd[0] = 23; fd[1] = 'hE8;
        push_frame(1);
        run(1, 1, 200);

        // Reset mid-frame
        @(negedge clock);
        in_valid = 1'b1; in_data = 8; sin = 3'd3; out_ready = 1'b1;
        @(negedge clock);
        in_data = 15;
        @(negedge clock);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_ready", in_ready, 1);
        exp_ovf = 1'b0;
        fd[0] = 96;
        push_frame(0);
        run(0, 0, 20);

        // sin changes after the seed are ignored
        dsin = 5;
        fd[0] = 50; fd[1] = 3;
        push_frame(1);
        dsin = -1;
        fd[0] = 40; fd[1] = 1; fd[2] = 2; fd[3] = 'hFF; fd[4] = 4; fd[5] = 5;
        push_frame(5);
        run(0, 0, 50);

        // Random frames with random valid/ready stalls
        for (int f = 0; f < 30; f++) begin
            int n;
            n = $urandom_range(0, 7);
            fd[0] = $urandom_range(0, 255);
            for (int i = 1; i <= n; i++)
                fd[i] = (f < 15) ? (($urandom_range(0, 40) - 20) & 255) : int'($urandom_range(0, 255));
            push_frame(n);
        end
        run(1, 1, 3000);
        for (int f = 0; f < 10; f++) begin
            int n;
            n = $urandom_range(0, 7);
            for (int i = 0; i <= n; i++)
                fd[i] = $urandom_range(0, 255);
            push_frame(n);
        end
        run(0, 1, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
